reg_scoreboard: RTL and testbench

Register-hazard controller for the decode stage's register-file read port. It tracks outstanding writes to each architectural register and grants decode access to the register file only when no operand hazard exists. It marks destinations pending on issue to EX and clears them on writeback. A drain sequence lets the core empty the pipeline before a flush or a debug halt.

---
 rtl/reg_scoreboard_pkg.sv | 8 +
 rtl/reg_scoreboard_if.sv | 29 ++
 rtl/reg_scoreboard_sb_counter.sv | 25 ++
 rtl/reg_scoreboard.sv | 84 ++++++++
 tb/tb_reg_scoreboard.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg: shared types and sizes for the register scoreboard (package sb_pkg).
package sb_pkg;
    localparam int NUM_REGS = 32;
    localparam int OUTST_W  = 7;
    localparam int SB_CNT_W = 2;
    typedef logic [SB_CNT_W-1:0] sb_cnt_t;
    typedef enum logic [1:0] {RUN, DRAIN, DRAINED} sb_state_e;
endpackage

// File: rtl/reg_scoreboard_if.sv
// reg_scoreboard_if: decode/writeback/drain signals between the core (master) and the scoreboard (slave).
interface reg_scoreboard_if;
    import sb_pkg::*;
    logic               ID_SB_req_i;
    logic [4:0]         ID_SB_rs1_i;
    logic [4:0]         ID_SB_rs2_i;
    logic               ID_SB_rs1_used_i;
    logic               ID_SB_rs2_used_i;
    logic [4:0]         ID_SB_rd_i;
    logic               ID_SB_rd_used_i;
    logic               ID_SB_issue_i;
    logic               WB_SB_valid_i;
    logic [4:0]         WB_SB_rd_i;
    logic               drain_i;
    logic               SB_ID_access_o;
    logic               drained_o;
    logic [OUTST_W-1:0] outstanding_o;
    logic               err_o;
    modport master (
        output ID_SB_req_i, ID_SB_rs1_i, ID_SB_rs2_i, ID_SB_rs1_used_i, ID_SB_rs2_used_i,
               ID_SB_rd_i, ID_SB_rd_used_i, ID_SB_issue_i, WB_SB_valid_i, WB_SB_rd_i, drain_i,
        input  SB_ID_access_o, drained_o, outstanding_o, err_o
    );
    modport slave (
        input  ID_SB_req_i, ID_SB_rs1_i, ID_SB_rs2_i, ID_SB_rs1_used_i, ID_SB_rs2_used_i,
               ID_SB_rd_i, ID_SB_rd_used_i, ID_SB_issue_i, WB_SB_valid_i, WB_SB_rd_i, drain_i,
        output SB_ID_access_o, drained_o, outstanding_o, err_o
    );
endinterface

// File: rtl/reg_scoreboard_sb_counter.sv
// sb_counter: per-register pending-write counter; simultaneous inc/dec cancel, decrement at zero flags underflow.
module sb_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         sat_o,
    output logic         uf_o
);
    logic [W-1:0] cnt_q, cnt_d;

    assign sat_o = &cnt_q;
    assign uf_o  = dec_i && !inc_i && cnt_q == '0;
    assign cnt_o = cnt_q;
    assign cnt_d = (inc_i && !dec_i && !sat_o) ? cnt_q + 1'b1 :
                   (dec_i && !inc_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;

    always_ff @(posedge clk) begin
        if (reset_i) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: grants decode register access only when no operand hazard exists; drain FSM halts grants.
// Define SB_WB_BYPASS_EN to treat a source whose last pending write retires this cycle as ready.
module reg_scoreboard
    import sb_pkg::*;
#(
    parameter int BITSIZE = 32,
    parameter int CNT_W   = SB_CNT_W
) (
    input  logic            clk,
    input  logic            reset_i,
    reg_scoreboard_if.slave sb
);
    sb_state_e          state_q, state_d;
    logic [OUTST_W-1:0] outstanding_q, outstanding_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt [NUM_REGS];
    logic [NUM_REGS-1:0] sat, uf;
    logic               access, inc_rd, wb_dec, byp1, byp2, hz1, hz2;

    if (BITSIZE < 1 || CNT_W < 1) begin : g_cfg_err
        $error("reg_scoreboard: BITSIZE and CNT_W must be positive");
    end

    // x0 is hard-wired as never pending, never saturated, never underflowing
    assign cnt[0] = '0;
    assign sat[0] = 1'b0;
    assign uf[0]  = 1'b0;
    assign inc_rd = access && sb.ID_SB_issue_i && sb.ID_SB_rd_used_i && sb.ID_SB_rd_i != '0;

    for (genvar g = 1; g < NUM_REGS; g++) begin : g_cnt
        sb_counter #(.W(CNT_W)) u_cnt (
            .clk    (clk),
            .reset_i(reset_i),
            .inc_i  (inc_rd && sb.ID_SB_rd_i == 5'(g)),
            .dec_i  (sb.WB_SB_valid_i && sb.WB_SB_rd_i == 5'(g)),
            .cnt_o  (cnt[g]),
            .sat_o  (sat[g]),
            .uf_o   (uf[g])
        );
    end

`ifdef SB_WB_BYPASS_EN
    assign byp1 = sb.WB_SB_valid_i && sb.WB_SB_rd_i == sb.ID_SB_rs1_i && cnt[sb.ID_SB_rs1_i] == CNT_W'(1);
    assign byp2 = sb.WB_SB_valid_i && sb.WB_SB_rd_i == sb.ID_SB_rs2_i && cnt[sb.ID_SB_rs2_i] == CNT_W'(1);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    assign hz1    = sb.ID_SB_rs1_used_i && cnt[sb.ID_SB_rs1_i] != '0 && !byp1;
    assign hz2    = sb.ID_SB_rs2_used_i && cnt[sb.ID_SB_rs2_i] != '0 && !byp2;
    assign access = sb.ID_SB_req_i && state_q == RUN && !hz1 && !hz2 &&
                    !(sb.ID_SB_rd_used_i && sat[sb.ID_SB_rd_i]);
    assign wb_dec = sb.WB_SB_valid_i && sb.WB_SB_rd_i != '0 && !uf[sb.WB_SB_rd_i];
    assign outstanding_d = outstanding_q + OUTST_W'(inc_rd) - OUTST_W'(wb_dec);
    assign err_d  = err_q || |uf;

    // a drain request with nothing left in flight skips straight to DRAINED
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (sb.drain_i) state_d = outstanding_d == '0 ? DRAINED : DRAIN;
            DRAIN:   state_d = !sb.drain_i ? RUN : (outstanding_d == '0 ? DRAINED : DRAIN);
            default: if (!sb.drain_i) state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q       <= RUN;
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
        end
    end

    assign sb.SB_ID_access_o = access;
    assign sb.drained_o      = state_q == DRAINED;
    assign sb.outstanding_o  = outstanding_q;
    assign sb.err_o          = err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed and random stimulus checked against a behavioural scoreboard model.
module tb_reg_scoreboard;
    import sb_pkg::*;

    typedef struct {
        string tag;
        logic  exp;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_scoreboard_if sbif ();
    reg_scoreboard #(.BITSIZE(32), .CNT_W(2)) dut (.clk(clk), .reset_i(rst), .sb(sbif));

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    int         m_cnt[32];
    int         m_out;
    logic       m_err;
    sb_state_e  m_st;
    logic       o_acc, o_err, o_drn;
    logic [6:0] o_out;

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic m_pend(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
`ifdef SB_WB_BYPASS_EN
        if (m_cnt[r] == 1 && sbif.WB_SB_valid_i && sbif.WB_SB_rd_i == r) return 1'b0;
`endif
        return m_cnt[r] != 0;
    endfunction

    function automatic logic m_access();
        if (!sbif.ID_SB_req_i || m_st != RUN) return 1'b0;
        if (sbif.ID_SB_rs1_used_i && m_pend(sbif.ID_SB_rs1_i)) return 1'b0;
        if (sbif.ID_SB_rs2_used_i && m_pend(sbif.ID_SB_rs2_i)) return 1'b0;
        if (sbif.ID_SB_rd_used_i && sbif.ID_SB_rd_i != 5'd0 && m_cnt[sbif.ID_SB_rd_i] == 3) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_out = 0;
        m_err = 1'b0;
        m_st  = RUN;
    endtask

    // one clock: drive at posedge+1, check at the falling edge, advance the model at the next posedge
    task automatic cyc(input logic req, input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                       input logic u2, input logic [4:0] rd, input logic ud, input logic iss,
                       input logic wbv, input logic [4:0] wbrd, input logic drn, input logic r);
        logic acc, inc, same;
        int   onext;
        exp_t e;
        sbif.ID_SB_req_i = req;  sbif.ID_SB_rs1_i = rs1; sbif.ID_SB_rs1_used_i = u1;
        sbif.ID_SB_rs2_i = rs2;  sbif.ID_SB_rs2_used_i = u2;
        sbif.ID_SB_rd_i = rd;    sbif.ID_SB_rd_used_i = ud; sbif.ID_SB_issue_i = iss;
        sbif.WB_SB_valid_i = wbv; sbif.WB_SB_rd_i = wbrd; sbif.drain_i = drn; rst = r;
        #4;
        acc = m_access();
        q.push_back('{"access", acc});
        o_acc = sbif.SB_ID_access_o; o_out = sbif.outstanding_o;
        o_err = sbif.err_o;          o_drn = sbif.drained_o;
        e = q.pop_front();
        chk(e.tag, 7'(o_acc), 7'(e.exp));
        chk("outstanding", o_out, 7'(m_out));
        chk("err", 7'(o_err), 7'(m_err));
        chk("drained", 7'(o_drn), 7'(m_st == DRAINED));
        @(posedge clk);
        if (r) model_reset();
        else begin
            inc   = iss && acc && ud && rd != 5'd0;
            same  = inc && wbv && wbrd == rd;
            onext = m_out;
            if (!same) begin
                if (inc) begin m_cnt[rd]++; onext++; end
                if (wbv && wbrd != 5'd0) begin
                    if (m_cnt[wbrd] == 0) m_err = 1'b1;
                    else begin m_cnt[wbrd]--; onext--; end
                end
            end
            case (m_st)
                RUN:     if (drn) m_st = (onext == 0) ? DRAINED : DRAIN;
                DRAIN:   m_st = !drn ? RUN : ((onext == 0) ? DRAINED : DRAIN);
                default: if (!drn) m_st = RUN;
            endcase
            m_out = onext;
        end
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic iss_rd(input logic [4:0] rd);
        cyc(1, 0, 0, 0, 0, rd, 1, 1, 0, 0, 0, 0);
    endtask

    task automatic wb(input logic [4:0] rd, input logic drn);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, rd, drn, 0);
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        sbif.ID_SB_req_i = 0; sbif.ID_SB_rs1_i = 0; sbif.ID_SB_rs1_used_i = 0;
        sbif.ID_SB_rs2_i = 0; sbif.ID_SB_rs2_used_i = 0; sbif.ID_SB_rd_i = 0;
        sbif.ID_SB_rd_used_i = 0; sbif.ID_SB_issue_i = 0; sbif.WB_SB_valid_i = 0;
        sbif.WB_SB_rd_i = 0; sbif.drain_i = 0;
        @(posedge clk); #1;
        chk("rst_outstanding", sbif.outstanding_o, 7'd0);
        chk("rst_err", 7'(sbif.err_o), 7'd0);
        chk("rst_drained", 7'(sbif.drained_o), 7'd0);

        // RAW hazard on x5 and its resolution by writeback
        iss_rd(5);
        cyc(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("raw_blocked", 7'(o_acc), 7'd0);
        cyc(1, 5, 1, 0, 0, 0, 0, 0, 1, 5, 0, 0);
`ifdef SB_WB_BYPASS_EN
        chk("raw_wb_cycle", 7'(o_acc), 7'd1);
`else
        chk("raw_wb_cycle", 7'(o_acc), 7'd0);
`endif
        cyc(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("raw_after_wb", 7'(o_acc), 7'd1);

        // saturation of x7
        iss_rd(7); iss_rd(7); iss_rd(7);
        cyc(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0);
        chk("sat_blocked", 7'(o_acc), 7'd0);
        chk("sat_outstanding", o_out, 7'd3);
        wb(7, 0); wb(7, 0); wb(7, 0);

        // x0 operands and destination
        cyc(1, 0, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0);
        chk("x0_access", 7'(o_acc), 7'd1);
        idle();
        chk("x0_outstanding", o_out, 7'd0);

        // same-cycle issue and writeback of x9 at zero
        cyc(1, 0, 0, 0, 0, 9, 1, 1, 1, 9, 0, 0);
        cyc(1, 9, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("same_no_err", 7'(o_err), 7'd0);
        chk("same_x9_free", 7'(o_acc), 7'd1);

        // writeback underflow sets sticky err
        wb(9, 0);
        idle();
        chk("uf_err", 7'(o_err), 7'd1);
        idle();
        chk("uf_err_sticky", 7'(o_err), 7'd1);

        // drain with two outstanding writes
        iss_rd(10); iss_rd(11);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("drain_edge_grant", 7'(o_acc), 7'd1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("drain_blocked", 7'(o_acc), 7'd0);
        wb(10, 1); wb(11, 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("drained_set", 7'(o_drn), 7'd1);
        chk("drained_blocked", 7'(o_acc), 7'd0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("resume_grant", 7'(o_acc), 7'd1);
        chk("resume_drained", 7'(o_drn), 7'd0);

        // mid-operation reset while draining with five writes pending
        iss_rd(1); iss_rd(2); iss_rd(3); iss_rd(4); iss_rd(5);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("pre_rst_outstanding", o_out, 7'd5);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        cyc(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("mid_rst_outstanding", o_out, 7'd0);
        chk("mid_rst_err", 7'(o_err), 7'd0);
        chk("mid_rst_drained", 7'(o_drn), 7'd0);
        chk("mid_rst_run", 7'(o_acc), 7'd1);

        // random traffic over a small register window
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 6)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                5'($urandom_range(0, 6)), 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 150) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
